music_sequencer: RTL and testbench

- Autonomous melody player; drives the same 16-bit one-hot active-high note vector that the beeper consumes. Acts as a ROM-scripted writer in place of the matrix keyboard.
- Steps through a song table of note/rest entries, holds each note for a beat-based duration, and inserts a short silent gap between entries.
- Top level muxes its output with the keyboard's inverted key_out before the beeper.

---
 rtl/music_seq_pkg.sv | 46 ++++
 rtl/music_seq_rom.sv | 79 +++++++
 rtl/music_sequencer.sv | 145 ++++++++++++++
 tb/tb_music_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/music_seq_pkg.sv
// Shared types and constants for the ROM-scripted melody player.
// Entry layout: [3:0] note index, [4] rest, [7:5] duration code (beats = code + 1).
package music_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      NOTE = 2'd2,
      GAP  = 2'd3
   } seq_state_t;

   localparam int NOTE_LSB = 0;
   localparam int NOTE_MSB = 3;
   localparam int REST_BIT = 4;
   localparam int DUR_LSB  = 5;
   localparam int DUR_MSB  = 7;

   localparam logic [7:0] END_MARKER = 8'hFF;

   // Note indices follow the keyboard's key order, so bit n of note_out is key n.
   localparam logic [3:0] NOTE_L_DO = 4'd0;
   localparam logic [3:0] NOTE_L_RE = 4'd1;
   localparam logic [3:0] NOTE_L_MI = 4'd2;
   localparam logic [3:0] NOTE_L_FA = 4'd3;
   localparam logic [3:0] NOTE_L_SO = 4'd4;
   localparam logic [3:0] NOTE_L_LA = 4'd5;
   localparam logic [3:0] NOTE_L_SI = 4'd6;
   localparam logic [3:0] NOTE_M_DO = 4'd7;
   localparam logic [3:0] NOTE_M_RE = 4'd8;
   localparam logic [3:0] NOTE_M_MI = 4'd9;
   localparam logic [3:0] NOTE_M_FA = 4'd10;
   localparam logic [3:0] NOTE_M_SO = 4'd11;
   localparam logic [3:0] NOTE_M_LA = 4'd12;
   localparam logic [3:0] NOTE_M_SI = 4'd13;
   localparam logic [3:0] NOTE_H_DO = 4'd14;
   localparam logic [3:0] NOTE_H_RE = 4'd15;

   function automatic logic [7:0] ent(input logic [3:0] n, input logic [2:0] d);
      return {d, 1'b0, n};
   endfunction

   function automatic logic [7:0] rest_ent(input logic [2:0] d);
      return {d, 1'b1, 4'h0};
   endfunction

endpackage

// File: rtl/music_seq_rom.sv
// Song table with a registered read port (one cycle from addr to data).
// SONG_SEL 0 is the shipped melody; 1..3 are short tables used for bring-up.
module music_seq_rom
   import music_seq_pkg::*;
#(
   parameter int unsigned SONG_SEL = 0
) (
   input  logic       clk,
   input  logic [7:0] addr,
   output logic [7:0] data
);

   logic [7:0] rom_word;

   always_comb begin
      rom_word = END_MARKER;
      if (SONG_SEL == 1) begin
         case (addr)
            8'd0:    rom_word = 8'h23;
            default: rom_word = END_MARKER;
         endcase
      end else if (SONG_SEL == 2) begin
         case (addr)
            8'd0:    rom_word = 8'h10;
            8'd1:    rom_word = 8'h41;
            default: rom_word = END_MARKER;
         endcase
      end else if (SONG_SEL == 3) begin
         // No end marker: the song ends on its last address.
         case (addr)
            8'd0:    rom_word = 8'h00;
            8'd1:    rom_word = 8'h25;
            8'd2:    rom_word = 8'h12;
            8'd3:    rom_word = 8'h4F;
            default: rom_word = END_MARKER;
         endcase
      end else begin
         case (addr)
            8'd0:    rom_word = ent(NOTE_M_DO, 3'd0);
            8'd1:    rom_word = ent(NOTE_M_DO, 3'd0);
            8'd2:    rom_word = ent(NOTE_M_SO, 3'd0);
            8'd3:    rom_word = ent(NOTE_M_SO, 3'd0);
            8'd4:    rom_word = ent(NOTE_M_LA, 3'd0);
            8'd5:    rom_word = ent(NOTE_M_LA, 3'd0);
            8'd6:    rom_word = ent(NOTE_M_SO, 3'd1);
            8'd7:    rom_word = ent(NOTE_M_FA, 3'd0);
            8'd8:    rom_word = ent(NOTE_M_FA, 3'd0);
            8'd9:    rom_word = ent(NOTE_M_MI, 3'd0);
            8'd10:   rom_word = ent(NOTE_M_MI, 3'd0);
            8'd11:   rom_word = ent(NOTE_M_RE, 3'd0);
            8'd12:   rom_word = ent(NOTE_M_RE, 3'd0);
            8'd13:   rom_word = ent(NOTE_M_DO, 3'd1);
            8'd14:   rom_word = ent(NOTE_M_SO, 3'd0);
            8'd15:   rom_word = ent(NOTE_M_SO, 3'd0);
            8'd16:   rom_word = ent(NOTE_M_FA, 3'd0);
            8'd17:   rom_word = ent(NOTE_M_FA, 3'd0);
            8'd18:   rom_word = ent(NOTE_M_MI, 3'd0);
            8'd19:   rom_word = ent(NOTE_M_MI, 3'd0);
            8'd20:   rom_word = ent(NOTE_M_RE, 3'd1);
            8'd21:   rom_word = ent(NOTE_M_SO, 3'd0);
            8'd22:   rom_word = ent(NOTE_M_SO, 3'd0);
            8'd23:   rom_word = ent(NOTE_M_FA, 3'd0);
            8'd24:   rom_word = ent(NOTE_M_FA, 3'd0);
            8'd25:   rom_word = ent(NOTE_M_MI, 3'd0);
            8'd26:   rom_word = ent(NOTE_M_MI, 3'd0);
            8'd27:   rom_word = ent(NOTE_M_RE, 3'd1);
            8'd28:   rom_word = rest_ent(3'd3);
            8'd29:   rom_word = ent(NOTE_H_DO, 3'd0);
            8'd30:   rom_word = ent(NOTE_M_SI, 3'd0);
            default: rom_word = END_MARKER;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      data <= rom_word;
   end

endmodule

// File: rtl/music_sequencer.sv
// ROM-scripted melody player driving the one-hot beeper note vector.
// Define MUSIC_SEQ_LOOP_EN to replay the song continuously until stop.
//
// state | meaning
// IDLE  | silent, addr held at 0, waiting for play
// LOAD  | one cycle; ROM word for addr is on rom_data
// NOTE  | note (or rest) sounding for the entry's beat time minus the gap
// GAP   | silent gap after each entry, then next entry or song end
module music_sequencer
   import music_seq_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 12_000_000,
   parameter int unsigned BEAT_MS  = 250,
   parameter int unsigned GAP_MS   = 20,
   parameter int unsigned SONG_LEN = 32,
   parameter int unsigned SONG_SEL = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        play,
   input  logic        stop,
   output logic [15:0] note_out,
   output logic        busy,
   output logic        done,
   output logic [7:0]  addr_dbg
);

   localparam int unsigned CPM       = CLK_FREQ / 1000;
   localparam logic [31:0] BEAT_CYC  = 32'(BEAT_MS * CPM);
   localparam logic [31:0] GAP_CYC   = 32'(GAP_MS * CPM);
   localparam logic [7:0]  LAST_ADDR = 8'(SONG_LEN - 1);

   seq_state_t  state;
   logic [31:0] timer;
   logic [7:0]  addr;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [31:0] note_load;

   // Timer is loaded with length-1 so each state occupies exactly its cycle count.
   assign note_load = (32'(rom_data[DUR_MSB:DUR_LSB]) + 32'd1) * BEAT_CYC - GAP_CYC - 32'd1;
   assign addr_dbg  = addr;

   // The ROM is registered, so it is fed the address that LOAD will need next cycle.
   always_comb begin
      rom_addr = addr;
      if (state == GAP && timer == '0 && !stop)
         rom_addr = (addr == LAST_ADDR) ? 8'd0 : addr + 8'd1;
`ifdef MUSIC_SEQ_LOOP_EN
      if (state == LOAD && rom_data == END_MARKER && !stop)
         rom_addr = 8'd0;
`endif
   end

   music_seq_rom #(
      .SONG_SEL (SONG_SEL)
   ) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         timer    <= '0;
         addr     <= '0;
         note_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (stop && state != IDLE) begin
            state    <= IDLE;
            timer    <= '0;
            addr     <= '0;
            note_out <= '0;
            busy     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  note_out <= '0;
                  addr     <= '0;
                  busy     <= 1'b0;
                  if (play && !stop) begin
                     state <= LOAD;
                     busy  <= 1'b1;
                  end
               end
               LOAD: begin
                  if (rom_data == END_MARKER) begin
                     done <= 1'b1;
                     addr <= '0;
`ifdef MUSIC_SEQ_LOOP_EN
                     state <= LOAD;
`else
                     state <= IDLE;
                     busy  <= 1'b0;
`endif
                  end else begin
                     state    <= NOTE;
                     timer    <= note_load;
                     note_out <= rom_data[REST_BIT] ? 16'h0000
                                 : (16'h0001 << rom_data[NOTE_MSB:NOTE_LSB]);
                  end
               end
               NOTE: begin
                  if (timer == '0) begin
                     state    <= GAP;
                     timer    <= GAP_CYC - 32'd1;
                     note_out <= '0;
                  end else begin
                     timer <= timer - 32'd1;
                  end
               end
               GAP: begin
                  if (timer == '0) begin
                     if (addr == LAST_ADDR) begin
                        done <= 1'b1;
                        addr <= '0;
`ifdef MUSIC_SEQ_LOOP_EN
                        state <= LOAD;
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                     end else begin
                        addr  <= addr + 8'd1;
                        state <= LOAD;
                     end
                  end else begin
                     timer <= timer - 32'd1;
                  end
               end
               default: begin
                  state    <= IDLE;
                  note_out <= '0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: three instances with different song tables,
// CPM=1, BEAT_MS=4, GAP_MS=1 (NOTE = 4*beats-1 cycles, GAP = 1 cycle).
module tb_music_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic play_a = 1'b0, stop_a = 1'b0, play_b = 1'b0, stop_b = 1'b0, play_c = 1'b0, stop_c = 1'b0;
   logic [15:0] note_a, note_b, note_c;
   logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic [7:0] addr_a, addr_b, addr_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   music_sequencer #(.CLK_FREQ(1000), .BEAT_MS(4), .GAP_MS(1), .SONG_LEN(2), .SONG_SEL(1)) u_a (
      .clk(clk), .rst_n(rst_n), .play(play_a), .stop(stop_a),
      .note_out(note_a), .busy(busy_a), .done(done_a), .addr_dbg(addr_a));

   music_sequencer #(.CLK_FREQ(1000), .BEAT_MS(4), .GAP_MS(1), .SONG_LEN(32), .SONG_SEL(2)) u_b (
      .clk(clk), .rst_n(rst_n), .play(play_b), .stop(stop_b),
      .note_out(note_b), .busy(busy_b), .done(done_b), .addr_dbg(addr_b));

   music_sequencer #(.CLK_FREQ(1000), .BEAT_MS(4), .GAP_MS(1), .SONG_LEN(4), .SONG_SEL(3)) u_c (
      .clk(clk), .rst_n(rst_n), .play(play_c), .stop(stop_c),
      .note_out(note_c), .busy(busy_c), .done(done_c), .addr_dbg(addr_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int dcnt, first_done, max_addr, busy_low, done_busy;
   logic [15:0] n2, n7, n16, n21;
   logic [7:0] addr34;

   initial begin
      repeat (3) tick();
      check("rst_note", 32'(note_a), 32'h0);
      check("rst_busy", 32'(busy_a), 32'h0);
      check("rst_done", 32'(done_a), 32'h0);
      check("rst_addr", 32'(addr_a), 32'h0);
      rst_n = 1'b1;
      tick();

      // Single note n=3 d=1 then end marker.
      play_a = 1'b1;
      tick();
      play_a = 1'b0;
      check("t1_load_busy", 32'(busy_a), 32'h1);
      check("t1_load_note", 32'(note_a), 32'h0);
      for (int i = 0; i < 7; i++) begin
         tick();
         check("t1_note", 32'(note_a), 32'h0008);
      end
      tick();
      check("t1_gap_note", 32'(note_a), 32'h0);
      check("t1_gap_busy", 32'(busy_a), 32'h1);
      tick();
      check("t1_load2_addr", 32'(addr_a), 32'h1);
      check("t1_load2_note", 32'(note_a), 32'h0);
      tick();
      check("t1_done", 32'(done_a), 32'h1);
      check("t1_done_addr", 32'(addr_a), 32'h0);
`ifdef MUSIC_SEQ_LOOP_EN
      check("t1_done_busy", 32'(busy_a), 32'h1);
      tick();
      check("t1_wrap_note", 32'(note_a), 32'h0008);
      stop_a = 1'b1;
      tick();
      stop_a = 1'b0;
      check("t1_stop_busy", 32'(busy_a), 32'h0);
`else
      check("t1_done_busy", 32'(busy_a), 32'h0);
      tick();
      check("t1_done_pulse", 32'(done_a), 32'h0);
      check("t1_idle_busy", 32'(busy_a), 32'h0);
`endif

      // stop and play together while idle.
      play_b = 1'b1;
      stop_b = 1'b1;
      tick();
      check("t2_sp_busy", 32'(busy_b), 32'h0);
      tick();
      check("t2_sp_busy2", 32'(busy_b), 32'h0);
      check("t2_sp_note", 32'(note_b), 32'h0);
      play_b = 1'b0;
      stop_b = 1'b0;

      // Rest entry, then n=1 d=2 interrupted by stop.
      play_b = 1'b1;
      tick();
      play_b = 1'b0;
      check("t2_load_busy", 32'(busy_b), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_rest_note", 32'(note_b), 32'h0);
         check("t2_rest_busy", 32'(busy_b), 32'h1);
      end
      tick();
      check("t2_gap_note", 32'(note_b), 32'h0);
      check("t2_gap_addr", 32'(addr_b), 32'h0);
      tick();
      check("t2_load_addr", 32'(addr_b), 32'h1);
      tick();
      check("t2_note1", 32'(note_b), 32'h0002);
      tick();
      tick();
      stop_b = 1'b1;
      tick();
      stop_b = 1'b0;
      check("t2_stop_note", 32'(note_b), 32'h0);
      check("t2_stop_busy", 32'(busy_b), 32'h0);
      check("t2_stop_addr", 32'(addr_b), 32'h0);
      dcnt = (done_b === 1'b1) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done_b === 1'b1) dcnt++;
      end
      check("t2_stop_nodone", 32'(dcnt), 32'h0);

      // Async reset in the middle of entry 1's note.
      play_b = 1'b1;
      tick();
      play_b = 1'b0;
      repeat (6) tick();
      check("t3_pre_note", 32'(note_b), 32'h0002);
      check("t3_pre_addr", 32'(addr_b), 32'h1);
      rst_n = 1'b0;
      #1;
      check("t3_rst_note", 32'(note_b), 32'h0);
      check("t3_rst_busy", 32'(busy_b), 32'h0);
      check("t3_rst_addr", 32'(addr_b), 32'h0);
      #1;
      rst_n = 1'b1;
      tick();
      play_b = 1'b1;
      tick();
      play_b = 1'b0;
      check("t3_restart_busy", 32'(busy_b), 32'h1);
      check("t3_restart_addr", 32'(addr_b), 32'h0);
      tick();
      check("t3_restart_note", 32'(note_b), 32'h0);
      stop_b = 1'b1;
      tick();
      stop_b = 1'b0;

      // Four-entry table without end marker; cycle 1 is LOAD of entry 0.
      play_c = 1'b1;
      tick();
      play_c = 1'b0;
      dcnt = 0; first_done = 0; max_addr = 0; busy_low = 0; done_busy = -1;
      n2 = '0; n7 = '0; n16 = '0; n21 = '0; addr34 = 8'hAA;
      for (int cyc = 2; cyc <= 70; cyc++) begin
         tick();
         if (done_c === 1'b1) begin
            dcnt++;
            if (first_done == 0) begin
               first_done = cyc;
               done_busy = int'(busy_c);
            end
         end
         if (int'(addr_c) > max_addr) max_addr = int'(addr_c);
         if (busy_c !== 1'b1 && first_done == 0) busy_low = 1;
         if (cyc == 2)  n2  = note_c;
         if (cyc == 7)  n7  = note_c;
         if (cyc == 16) n16 = note_c;
         if (cyc == 21) n21 = note_c;
         if (cyc == 34) addr34 = addr_c;
      end
      check("t4_note0", 32'(n2), 32'h0001);
      check("t4_note1", 32'(n7), 32'h0020);
      check("t4_rest2", 32'(n16), 32'h0);
      check("t4_note3", 32'(n21), 32'h8000);
      check("t4_first_done", 32'(first_done), 32'd33);
      check("t4_max_addr", 32'(max_addr), 32'd3);
      check("t4_busy_before_done", 32'(busy_low), 32'h0);
      check("t4_addr_after", 32'(addr34), 32'h0);
`ifdef MUSIC_SEQ_LOOP_EN
      check("t4_done_count", 32'(dcnt), 32'd2);
      check("t4_done_busy", 32'(done_busy), 32'h1);
      check("t4_busy_end", 32'(busy_c), 32'h1);
      stop_c = 1'b1;
      tick();
      stop_c = 1'b0;
      check("t4_stop_busy", 32'(busy_c), 32'h0);
`else
      check("t4_done_count", 32'(dcnt), 32'd1);
      check("t4_done_busy", 32'(done_busy), 32'h0);
      check("t4_busy_end", 32'(busy_c), 32'h0);
`endif

      // play held high through the song.
      play_a = 1'b1;
      tick();
      repeat (4) tick();
      check("t5_mid_note", 32'(note_a), 32'h0008);
      check("t5_mid_busy", 32'(busy_a), 32'h1);
      repeat (5) tick();
      check("t5_load2_addr", 32'(addr_a), 32'h1);
      tick();
      check("t5_done", 32'(done_a), 32'h1);
`ifdef MUSIC_SEQ_LOOP_EN
      tick();
      check("t5_wrap_note", 32'(note_a), 32'h0008);
`else
      check("t5_done_busy", 32'(busy_a), 32'h0);
      tick();
      check("t5_reload_busy", 32'(busy_a), 32'h1);
      check("t5_reload_addr", 32'(addr_a), 32'h0);
      check("t5_reload_note", 32'(note_a), 32'h0);
      tick();
      check("t5_replay_note", 32'(note_a), 32'h0008);
`endif
      stop_a = 1'b1;
      tick();
      check("t5_stop_busy", 32'(busy_a), 32'h0);
      tick();
      check("t5_stop_wins", 32'(busy_a), 32'h0);
      check("t5_stop_note", 32'(note_a), 32'h0);
      play_a = 1'b0;
      stop_a = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
